// File: rtl/ddr4_cmd_monitor.sv
// DDR4 command/address bus monitor.
// Decodes commands, tracks bank state, flags protocol errors, counts commands.
module ddr4_cmd_monitor #(
    parameter int unsigned TRCD_CYC = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clock,
    input  logic             sys_reset,
    input  logic             c0_ddr4_act_n,
    input  logic [16:0]      c0_ddr4_adr,
    input  logic [1:0]       c0_ddr4_ba,
    input  logic             c0_ddr4_bg,
    input  logic             c0_ddr4_cs_n,
    input  logic             c0_ddr4_cke,
    input  logic             clear_counters,
    output logic             cmd_valid,
    output logic [3:0]       cmd_code,
    output logic [2:0]       cmd_bank,
    output logic [16:0]      cmd_row,
    output logic [9:0]       cmd_col,
    output logic             cmd_ap,
    output logic [7:0]       open_banks,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] cnt_act,
    output logic [CNT_W-1:0] cnt_rd,
    output logic [CNT_W-1:0] cnt_wr,
    output logic [CNT_W-1:0] cnt_pre,
    output logic [CNT_W-1:0] cnt_ref
);

    localparam logic [3:0] C_ACT  = 4'd0;
    localparam logic [3:0] C_RD   = 4'd1;
    localparam logic [3:0] C_WR   = 4'd2;
    localparam logic [3:0] C_PRE  = 4'd3;
    localparam logic [3:0] C_PREA = 4'd4;
    localparam logic [3:0] C_REF  = 4'd5;
    localparam logic [3:0] C_MRS  = 4'd6;
    localparam logic [3:0] C_ZQC  = 4'd7;
    localparam logic [3:0] C_RFU  = 4'd8;

    localparam logic [7:0] TRCD_LOAD = 8'(TRCD_CYC - 1);

    logic       dec_valid;
    logic [3:0] dec_code;
    logic [2:0] dec_bank;
    logic       dec_act;
    logic       dec_rdwr;
    logic       dec_ap;
    logic [2:0] dec_err;
    logic [7:0] open_q;
    logic [7:0] trcd_q [8];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign dec_bank   = {c0_ddr4_bg, c0_ddr4_ba};
    assign dec_act    = dec_valid && (dec_code == C_ACT);
    assign dec_rdwr   = dec_valid && ((dec_code == C_RD) || (dec_code == C_WR));
    assign dec_ap     = dec_rdwr && c0_ddr4_adr[10];
    assign open_banks = open_q;

    // Decode the sampled pins into a command; deselect, CKE low and NOP give nothing
    always_comb begin
        dec_valid = 1'b0;
        dec_code  = C_ACT;
        if (!c0_ddr4_cs_n && c0_ddr4_cke) begin
            dec_valid = 1'b1;
            if (c0_ddr4_act_n) begin
                case (c0_ddr4_adr[16:14])
                    3'b000:  dec_code = C_MRS;
                    3'b001:  dec_code = C_REF;
                    3'b010:  dec_code = c0_ddr4_adr[10] ? C_PREA : C_PRE;
                    3'b011:  dec_code = C_RFU;
                    3'b100:  dec_code = C_WR;
                    3'b101:  dec_code = C_RD;
                    3'b110:  dec_code = C_ZQC;
                    default: dec_valid = 1'b0;
                endcase
            end
        end
    end

    // Protocol checks against the bank table as it stood before this command
    always_comb begin
        dec_err = 3'd0;
        if (dec_valid) begin
            case (dec_code)
                C_ACT: if (open_q[dec_bank]) dec_err = 3'd1;
                C_RD, C_WR: begin
                    if (!open_q[dec_bank])
                        dec_err = 3'd2;
                    else if (trcd_q[dec_bank] != 8'd0)
                        dec_err = 3'd3;
                end
                C_REF: if (|open_q) dec_err = 3'd4;
                C_RFU: dec_err = 3'd5;
                default: dec_err = 3'd0;
            endcase
        end
    end

    // Register the decoded command and error report
    always_ff @(posedge clock) begin
        if (sys_reset) begin
            cmd_valid  <= 1'b0;
            cmd_code   <= 4'd0;
            cmd_bank   <= 3'd0;
            cmd_row    <= 17'd0;
            cmd_col    <= 10'd0;
            cmd_ap     <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= 3'd0;
            err_sticky <= 1'b0;
        end else begin
            cmd_valid  <= dec_valid;
            cmd_code   <= dec_valid ? dec_code : 4'd0;
            cmd_bank   <= dec_valid ? dec_bank : 3'd0;
            cmd_row    <= dec_act ? c0_ddr4_adr : 17'd0;
            cmd_col    <= dec_rdwr ? c0_ddr4_adr[9:0] : 10'd0;
            cmd_ap     <= dec_ap;
            err_valid  <= (dec_err != 3'd0);
            err_code   <= dec_err;
            err_sticky <= err_sticky | (dec_err != 3'd0);
        end
    end

    // Per-bank open flag and tRCD down-counter
    always_ff @(posedge clock) begin
        for (int b = 0; b < 8; b++) begin
            if (sys_reset) begin
                open_q[b] <= 1'b0;
                trcd_q[b] <= 8'd0;
            end else if (dec_act && (dec_bank == 3'(b))) begin
                open_q[b] <= 1'b1;
                trcd_q[b] <= TRCD_LOAD;
            end else begin
                if (trcd_q[b] != 8'd0)
                    trcd_q[b] <= trcd_q[b] - 8'd1;
                if ((dec_valid && (dec_code == C_PREA)) ||
                    (dec_valid && (dec_code == C_PRE) && (dec_bank == 3'(b))) ||
                    (dec_ap && (dec_bank == 3'(b))))
                    open_q[b] <= 1'b0;
            end
        end
    end

    // Saturating statistics; a clear drops any same-cycle increment
    always_ff @(posedge clock) begin
        if (sys_reset || clear_counters) begin
            cnt_act <= '0;
            cnt_rd  <= '0;
            cnt_wr  <= '0;
            cnt_pre <= '0;
            cnt_ref <= '0;
        end else if (dec_valid) begin
            case (dec_code)
                C_ACT:         cnt_act <= sat_inc(cnt_act);
                C_RD:          cnt_rd  <= sat_inc(cnt_rd);
                C_WR:          cnt_wr  <= sat_inc(cnt_wr);
                C_PRE, C_PREA: cnt_pre <= sat_inc(cnt_pre);
                C_REF:         cnt_ref <= sat_inc(cnt_ref);
                default:       ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr4_cmd_monitor.sv
// Bench for ddr4_cmd_monitor.
// Reference model predicts each cycle's outputs into a queue checked one edge later.
module tb_ddr4_cmd_monitor;

    localparam int TRCD = 16;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clock = 1'b0;
    logic          sys_reset;
    logic          c0_ddr4_act_n;
    logic [16:0]   c0_ddr4_adr;
    logic [1:0]    c0_ddr4_ba;
    logic          c0_ddr4_bg;
    logic          c0_ddr4_cs_n;
    logic          c0_ddr4_cke;
    logic          clear_counters;
    logic          cmd_valid;
    logic [3:0]    cmd_code;
    logic [2:0]    cmd_bank;
    logic [16:0]   cmd_row;
    logic [9:0]    cmd_col;
    logic          cmd_ap;
    logic [7:0]    open_banks;
    logic          err_valid;
    logic [2:0]    err_code;
    logic          err_sticky;
    logic [CW-1:0] cnt_act, cnt_rd, cnt_wr, cnt_pre, cnt_ref;

    ddr4_cmd_monitor #(.TRCD_CYC(TRCD), .CNT_W(CW)) dut (
        .clock(clock), .sys_reset(sys_reset),
        .c0_ddr4_act_n(c0_ddr4_act_n), .c0_ddr4_adr(c0_ddr4_adr),
        .c0_ddr4_ba(c0_ddr4_ba), .c0_ddr4_bg(c0_ddr4_bg),
        .c0_ddr4_cs_n(c0_ddr4_cs_n), .c0_ddr4_cke(c0_ddr4_cke),
        .clear_counters(clear_counters),
        .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_ap(cmd_ap),
        .open_banks(open_banks), .err_valid(err_valid), .err_code(err_code),
        .err_sticky(err_sticky),
        .cnt_act(cnt_act), .cnt_rd(cnt_rd), .cnt_wr(cnt_wr),
        .cnt_pre(cnt_pre), .cnt_ref(cnt_ref)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [3:0]  code;
        logic [2:0]  bank;
        logic [16:0] row;
        logic [9:0]  col;
        logic        ap;
        logic [2:0]  err;
        logic [7:0]  open;
        logic        sticky;
        int          cnt [5];
    } exp_t;

    exp_t q [$];

    int checks = 0;
    int errors = 0;

    bit m_open [8];
    int m_act  [8];
    int m_cyc  = 0;
    int m_cnt  [5];
    bit m_sticky;

    function automatic logic [16:0] ca(input logic [2:0] op, input logic ap,
                                       input logic [9:0] col);
        return {op, 3'b000, ap, col};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_open[i] = 1'b0;
            m_act[i]  = 0;
        end
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_sticky = 1'b0;
    endtask

    task automatic step(input logic cs, input logic ke, input logic an,
                        input logic [16:0] a, input logic [2:0] bk,
                        input logic clr, input logic rst);
        exp_t e;
        int   idx;
        sys_reset      = rst;
        c0_ddr4_cs_n   = cs;
        c0_ddr4_cke    = ke;
        c0_ddr4_act_n  = an;
        c0_ddr4_adr    = a;
        c0_ddr4_bg     = bk[2];
        c0_ddr4_ba     = bk[1:0];
        clear_counters = clr;
        e.valid = 0; e.code = 0; e.bank = 0; e.row = 0;
        e.col = 0; e.ap = 0; e.err = 0;
        idx = -1;
        if (rst) begin
            model_reset();
        end else begin
            if (!cs && ke) begin
                e.valid = 1'b1;
                if (!an) e.code = 4'd0;
                else begin
                    case (a[16:14])
                        3'd0: e.code = 4'd6;
                        3'd1: e.code = 4'd5;
                        3'd2: e.code = a[10] ? 4'd4 : 4'd3;
                        3'd3: e.code = 4'd8;
                        3'd4: e.code = 4'd2;
                        3'd5: e.code = 4'd1;
                        3'd6: e.code = 4'd7;
                        default: e.valid = 1'b0;
                    endcase
                end
            end
            if (e.valid) begin
                e.bank = bk;
                if (e.code == 0) begin
                    e.row = a;
                    if (m_open[bk]) e.err = 3'd1;
                    m_open[bk] = 1'b1;
                    m_act[bk]  = m_cyc;
                    idx = 0;
                end else if (e.code == 1 || e.code == 2) begin
                    e.col = a[9:0];
                    e.ap  = a[10];
                    if (!m_open[bk]) e.err = 3'd2;
                    else if (m_cyc - m_act[bk] < TRCD) e.err = 3'd3;
                    if (a[10]) m_open[bk] = 1'b0;
                    idx = (e.code == 1) ? 1 : 2;
                end else if (e.code == 3) begin
                    m_open[bk] = 1'b0;
                    idx = 3;
                end else if (e.code == 4) begin
                    for (int i = 0; i < 8; i++) m_open[i] = 1'b0;
                    idx = 3;
                end else if (e.code == 5) begin
                    for (int i = 0; i < 8; i++) if (m_open[i]) e.err = 3'd4;
                    idx = 4;
                end else if (e.code == 8) begin
                    e.err = 3'd5;
                end
            end
            if (clr) for (int i = 0; i < 5; i++) m_cnt[i] = 0;
            else if (idx >= 0 && m_cnt[idx] < CMAX) m_cnt[idx]++;
            if (e.err != 0) m_sticky = 1'b1;
        end
        for (int i = 0; i < 8; i++) e.open[i] = m_open[i];
        e.sticky = m_sticky;
        for (int i = 0; i < 5; i++) e.cnt[i] = m_cnt[i];
        m_cyc++;
        q.push_back(e);

        @(posedge clock);
        #1;
        e = q.pop_front();
        chk("cmd_valid", 32'(cmd_valid), 32'(e.valid));
        chk("cmd_code", 32'(cmd_code), 32'(e.code));
        chk("cmd_bank", 32'(cmd_bank), 32'(e.bank));
        chk("cmd_row", 32'(cmd_row), 32'(e.row));
        chk("cmd_col", 32'(cmd_col), 32'(e.col));
        chk("cmd_ap", 32'(cmd_ap), 32'(e.ap));
        chk("err_valid", 32'(err_valid), 32'(e.err != 0));
        chk("err_code", 32'(err_code), 32'(e.err));
        chk("err_sticky", 32'(err_sticky), 32'(e.sticky));
        chk("open_banks", 32'(open_banks), 32'(e.open));
        chk("cnt_act", 32'(cnt_act), 32'(e.cnt[0]));
        chk("cnt_rd", 32'(cnt_rd), 32'(e.cnt[1]));
        chk("cnt_wr", 32'(cnt_wr), 32'(e.cnt[2]));
        chk("cnt_pre", 32'(cnt_pre), 32'(e.cnt[3]));
        chk("cnt_ref", 32'(cnt_ref), 32'(e.cnt[4]));
    endtask

    task automatic cmd(input logic an, input logic [16:0] a,
                       input logic [2:0] bk, input logic clr);
        step(1'b0, 1'b1, an, a, bk, clr, 1'b0);
    endtask

    task automatic nop();
        step(1'b1, 1'b1, 1'b1, 17'h1FFFF, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic rst();
        step(1'b1, 1'b0, 1'b1, 17'd0, 3'd0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        rst();
        rst();

        // ACT bg=1 ba=2
        cmd(1'b0, 17'h1ABCD, 3'd6, 1'b0);
        nop();

        // tRCD boundary on bank 0: k=15 errors, k=16 is clean
        cmd(1'b0, 17'h00123, 3'd0, 1'b0);
        repeat (14) nop();
        cmd(1'b1, ca(3'b101, 1'b0, 10'h02A), 3'd0, 1'b0);
        cmd(1'b1, ca(3'b101, 1'b0, 10'h155), 3'd0, 1'b0);

        // WR to closed bank, PRE to closed bank
        rst();
        cmd(1'b1, ca(3'b100, 1'b0, 10'h005), 3'd3, 1'b0);
        cmd(1'b1, ca(3'b010, 1'b0, 10'h000), 3'd3, 1'b0);

        // REF with banks open, then PREA and clean REF
        rst();
        cmd(1'b0, 17'h00011, 3'd1, 1'b0);
        cmd(1'b0, 17'h00055, 3'd5, 1'b0);
        cmd(1'b1, ca(3'b001, 1'b0, 10'h000), 3'd0, 1'b0);
        cmd(1'b1, ca(3'b010, 1'b1, 10'h000), 3'd0, 1'b0);
        cmd(1'b1, ca(3'b001, 1'b0, 10'h000), 3'd0, 1'b0);

        // MRS, ZQC, RFU decode
        cmd(1'b1, ca(3'b000, 1'b0, 10'h0AA), 3'd2, 1'b0);
        cmd(1'b1, ca(3'b110, 1'b1, 10'h000), 3'd7, 1'b0);
        cmd(1'b1, ca(3'b011, 1'b0, 10'h000), 3'd4, 1'b0);

        // auto-precharge closes the bank; next RD hits a closed bank
        cmd(1'b0, 17'h0F0F0, 3'd2, 1'b0);
        repeat (16) nop();
        cmd(1'b1, ca(3'b101, 1'b1, 10'h3FF), 3'd2, 1'b0);
        cmd(1'b1, ca(3'b101, 1'b0, 10'h001), 3'd2, 1'b0);

        // counter saturation and clear-wins
        step(1'b1, 1'b1, 1'b1, 17'h1FFFF, 3'd0, 1'b1, 1'b0);
        repeat (17) cmd(1'b1, ca(3'b100, 1'b0, 10'h010), 3'd7, 1'b0);
        cmd(1'b1, ca(3'b100, 1'b0, 10'h020), 3'd7, 1'b1);

        // non-commands leave state untouched; ACT to open bank
        cmd(1'b0, 17'h04444, 3'd4, 1'b0);
        step(1'b1, 1'b1, 1'b0, 17'h1ABCD, 3'd1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 17'h1ABCD, 3'd1, 1'b0, 1'b0);
        cmd(1'b1, ca(3'b111, 1'b0, 10'h000), 3'd4, 1'b0);
        cmd(1'b0, 17'h05555, 3'd4, 1'b0);

        // reset between ACT and RD discards the open bank
        rst();
        cmd(1'b0, 17'h06666, 3'd4, 1'b0);
        rst();
        repeat (16) nop();
        cmd(1'b1, ca(3'b101, 1'b0, 10'h077), 3'd4, 1'b0);
        nop();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
